// File: rtl/register_file_16x32.sv
// register_file_16x32: R0-R14 storage with R15 mapped to PC_in, three bypassed read ports,
// write-back plus link-register write, and a sticky flag for attempted R15 writes.
module register_file_16x32 #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        RA,
    input  logic [3:0]        RB,
    input  logic [3:0]        RD,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [DATA_W-1:0] PD,
    input  logic [DATA_W-1:0] PC_in,
    input  logic              WB_RF_enable,
    input  logic [3:0]        WB_addr,
    input  logic [DATA_W-1:0] WB_data,
    input  logic              LR_enable,
    input  logic [DATA_W-1:0] LR_data,
    output logic              R15_write_err
);
    logic [DATA_W-1:0] r_regs [0:14];
    logic [3:0]        w_addr [0:2];
    logic [DATA_W-1:0] w_rd   [0:2];
    logic              w_wb_ok;

    assign w_wb_ok = WB_RF_enable && (WB_addr != 4'd15);
    assign w_addr[0] = RA;
    assign w_addr[1] = RB;
    assign w_addr[2] = RD;

    // LR bypass is checked before WB so the younger link write wins on R14
    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign w_rd[g] = (w_addr[g] == 4'd15)                   ? PC_in   :
                         (LR_enable && w_addr[g] == 4'd14)      ? LR_data :
                         (w_wb_ok && w_addr[g] == WB_addr)      ? WB_data :
                                                                  r_regs[w_addr[g]];
    end

    assign PA = w_rd[0];
    assign PB = w_rd[1];
    assign PD = w_rd[2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 15; i++) r_regs[i] <= RESET_VAL;
            R15_write_err <= 1'b0;
        end else begin
            if (w_wb_ok) r_regs[WB_addr] <= WB_data;
            if (LR_enable) r_regs[14] <= LR_data;
            if (WB_RF_enable && WB_addr == 4'd15) R15_write_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_register_file_16x32.sv
// tb_register_file_16x32: directed scenarios plus randomized traffic against an array-based model.
module tb_register_file_16x32;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  RA, RB, RD, WB_addr;
    logic [31:0] PA, PB, PD, PC_in, WB_data, LR_data;
    logic        WB_RF_enable, LR_enable, R15_write_err;

    logic [31:0] m_regs [0:14];
    logic        m_err;
    int          n_chk = 0;
    int          n_pass = 0;

    register_file_16x32 dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RD(RD),
        .PA(PA), .PB(PB), .PD(PD), .PC_in(PC_in),
        .WB_RF_enable(WB_RF_enable), .WB_addr(WB_addr), .WB_data(WB_data),
        .LR_enable(LR_enable), .LR_data(LR_data), .R15_write_err(R15_write_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural view: PC for R15, then the pending link write, then the pending WB write, else storage
    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 15) return PC_in;
        if (LR_enable && a == 14) return LR_data;
        if (WB_RF_enable && WB_addr != 15 && a == WB_addr) return WB_data;
        return m_regs[a];
    endfunction

    task automatic check_reads(input string tag);
        #1;
        chk({tag, "_PA"}, PA, m_read(RA));
        chk({tag, "_PB"}, PB, m_read(RB));
        chk({tag, "_PD"}, PD, m_read(RD));
    endtask

    task automatic edge_step();
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
            m_err = 1'b0;
        end else begin
            if (WB_RF_enable) begin
                if (WB_addr == 15) m_err = 1'b1;
                else m_regs[WB_addr] = WB_data;
            end
            if (LR_enable) m_regs[14] = LR_data;
        end
        @(negedge Clk);
    endtask

    task automatic idle();
        WB_RF_enable = 0; LR_enable = 0; Reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 15; i++) m_regs[i] = 32'hx;
        m_err = 1'bx;
        Reset = 1; RA = 0; RB = 0; RD = 0; PC_in = 0;
        WB_RF_enable = 0; WB_addr = 0; WB_data = 0; LR_enable = 0; LR_data = 0;
        @(negedge Clk);
        edge_step();
        idle();
        RA = 0; RB = 7; RD = 14;
        #1;
        chk("rst_PA", PA, 32'h0);
        chk("rst_PB", PB, 32'h0);
        chk("rst_PD", PD, 32'h0);
        chk("rst_err", {31'b0, R15_write_err}, 32'h0);

        WB_RF_enable = 1; WB_addr = 3; WB_data = 32'hDEADBEEF; RA = 3;
        #1 chk("wb_bypass", PA, 32'hDEADBEEF);
        edge_step();
        idle();
        #1 chk("wb_stored", PA, 32'hDEADBEEF);

        PC_in = 32'h10; RB = 15; WB_RF_enable = 1; WB_addr = 15; WB_data = 32'h1234;
        #1 chk("r15_read", PB, 32'h10);
        edge_step();
        idle();
        #1;
        chk("r15_err", {31'b0, R15_write_err}, 32'h1);
        chk("r15_read_after", PB, 32'h10);

        WB_RF_enable = 1; WB_addr = 14; WB_data = 32'hAAAA0000;
        LR_enable = 1; LR_data = 32'h24; RD = 14;
        #1 chk("lr_bypass", PD, 32'h24);
        edge_step();
        idle();
        #1 chk("lr_stored", PD, 32'h24);

        WB_RF_enable = 1; WB_addr = 5; WB_data = 32'h55;
        edge_step();
        WB_addr = 6; WB_data = 32'h66;
        edge_step();
        idle();
        RA = 5; RB = 6; RD = 5;
        #1;
        chk("multi_PA", PA, 32'h55);
        chk("multi_PB", PB, 32'h66);
        chk("multi_PD", PD, 32'h55);

        WB_RF_enable = 1; WB_addr = 9; WB_data = 32'hFFFFFFFF;
        edge_step();
        Reset = 1; WB_addr = 9; WB_data = 32'h1; RA = 9;
        #1 chk("rst_bypass", PA, 32'h1);
        edge_step();
        idle();
        #1;
        chk("rst_drop", PA, 32'h0);
        chk("rst_err_clr", {31'b0, R15_write_err}, 32'h0);

        for (int c = 0; c < 400; c++) begin
            Reset = ($urandom_range(0, 31) == 0);
            RA = 4'($urandom); RB = 4'($urandom); RD = 4'($urandom);
            if ($urandom_range(0, 3) == 0) RB = RA;
            PC_in = $urandom;
            WB_RF_enable = $urandom_range(0, 1) == 1;
            WB_addr = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom);
            WB_data = $urandom;
            LR_enable = $urandom_range(0, 3) == 0;
            LR_data = $urandom;
            check_reads("rnd");
            edge_step();
            chk("rnd_err", {31'b0, R15_write_err}, {31'b0, m_err});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
